mxu_data_setup: RTL and testbench



---
 rtl/mxu_data_setup_pkg.sv | 14 +
 rtl/mxu_vec_fifo.sv | 54 +++++
 rtl/mxu_data_setup.sv | 116 +++++++++++
 tb/tb_mxu_data_setup.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mxu_data_setup_pkg.sv
// Shared geometry defaults and state encoding for the MXU data-setup stage.
package mxu_data_setup_pkg;

    localparam int unsigned MXU_ROWS       = 4;
    localparam int unsigned MXU_BIT_WIDTH  = 4;
    localparam int unsigned MXU_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } setup_state_t;

endpackage

// File: rtl/mxu_vec_fifo.sv
// Synchronous first-word-fall-through vector FIFO with occupancy count.
module mxu_vec_fifo
    import mxu_data_setup_pkg::*;
#(
    parameter int unsigned width = MXU_ROWS * MXU_BIT_WIDTH + 1,
    parameter int unsigned depth = MXU_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [width-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [width-1:0]       rd_data,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (aw + 1)'(depth));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mxu_data_setup.sv
// Systolic data setup: buffers activation vectors and skews them diagonally
// so row r of the MAC array sees its element r cycles after row 0.
module mxu_data_setup
    import mxu_data_setup_pkg::*;
#(
    parameter int unsigned bit_width = MXU_BIT_WIDTH,
    parameter int unsigned n_rows    = MXU_ROWS,
    parameter int unsigned depth     = MXU_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [n_rows*bit_width-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    input  logic                        stall,
    output logic [n_rows*bit_width-1:0] out_data,
    output logic [n_rows-1:0]           out_valid,
    output logic                        mac_ce,
    output logic                        done,
    output logic                        busy
);

    localparam int unsigned vec_w = n_rows * bit_width;

    logic [vec_w:0]          fifo_rd_data;
    logic [$clog2(depth):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    pop_last;
    logic [vec_w-1:0]        pop_data;
    logic [n_rows-1:0]       tag;
    logic [n_rows-1:0]       row_active;
    setup_state_t            state;
    setup_state_t            state_n;

    mxu_vec_fifo #(
        .width (vec_w + 1),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid),
        .wr_data ({in_last, in_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = ~fifo_full;
    assign pop      = ~stall & ~fifo_empty & (state != DRAIN);
    assign pop_data = fifo_rd_data[vec_w-1:0];
    assign pop_last = fifo_rd_data[vec_w];
    assign mac_ce   = ~stall;
    assign busy     = (state != IDLE);

    for (genvar r = 0; r < n_rows; r++) begin : g_row
        logic [bit_width-1:0] data_q [r+1];
        logic [r:0]           vld_q;

        // Stage 0 takes a bubble (zero, invalid) whenever nothing is popped.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i <= r; i++) data_q[i] <= '0;
                vld_q <= '0;
            end else if (~stall) begin
                for (int unsigned i = r; i > 0; i--) begin
                    data_q[i] <= data_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
                data_q[0] <= pop ? pop_data[r*bit_width +: bit_width] : '0;
                vld_q[0]  <= pop;
            end
        end

        assign out_data[r*bit_width +: bit_width] = vld_q[r] ? data_q[r] : '0;
        assign out_valid[r]  = vld_q[r];
        assign row_active[r] = |vld_q;
    end

    // Last tag shadows the deepest row so done lines up with its final element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       tag <= '0;
        else if (~stall) tag <= {tag[n_rows-2:0], pop & pop_last};
    end

    assign done = tag[n_rows-1] & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (pop) state_n = pop_last ? DRAIN : STREAM;
            end
            STREAM: begin
                if (pop && pop_last)
                    state_n = DRAIN;
                else if (fifo_count == '0 && row_active == '0)
                    state_n = IDLE;
            end
            DRAIN: begin
                if (done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mxu_data_setup.sv
// Directed bench for mxu_data_setup at bit_width=4, n_rows=4, depth=4.
module tb_mxu_data_setup;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        stall;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic        mac_ce;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mxu_data_setup #(
        .bit_width (4),
        .n_rows    (4),
        .depth     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .stall     (stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .mac_ce    (mac_ce),
        .done      (done),
        .busy      (busy)
    );

    // Each element: bit 4 = expected valid, bits 3:0 = expected data.
    function automatic logic [19:0] mk(input logic [4:0] e0, input logic [4:0] e1,
                                       input logic [4:0] e2, input logic [4:0] e3);
        return {e3[4], e2[4], e1[4], e0[4], e3[3:0], e2[3:0], e1[3:0], e0[3:0]};
    endfunction

    function automatic logic [15:0] v4(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic rows(input string tag, input logic [19:0] exp);
        chk(tag, {out_valid, out_data}, exp);
    endtask

    // Advance one cycle, then apply this cycle's inputs and let them settle.
    task automatic go(input logic v, input logic [15:0] d, input logic l, input logic s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        stall    = s;
        #1;
    endtask

    logic [19:0] t2 [7];
    logic [19:0] t3 [9];

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        stall    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        rows("rst_rows", 20'h0);
        chk1("rst_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ce", mac_ce, 1'b1);

        // Single tagged vector 1,2,3,4
        go(1'b1, v4(1, 2, 3, 4), 1'b1, 1'b0);
        chk1("t1_ready", in_ready, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_pop", 20'h0);
        chk1("t1_busy0", busy, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_r0", mk(5'h11, 5'h00, 5'h00, 5'h00));
        chk1("t1_busy1", busy, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_r1", mk(5'h00, 5'h12, 5'h00, 5'h00));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_r2", mk(5'h00, 5'h00, 5'h13, 5'h00));
        chk1("t1_nodone", done, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_r3", mk(5'h00, 5'h00, 5'h00, 5'h14));
        chk1("t1_done", done, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t1_after", 20'h0);
        chk1("t1_idle", busy, 1'b0);
        chk1("t1_done_off", done, 1'b0);

        // Back-to-back A,B,C with last on C
        t2 = '{mk(5'h11, 5'h00, 5'h00, 5'h00), mk(5'h15, 5'h12, 5'h00, 5'h00),
               mk(5'h19, 5'h16, 5'h13, 5'h00), mk(5'h00, 5'h1A, 5'h17, 5'h14),
               mk(5'h00, 5'h00, 5'h1B, 5'h18), mk(5'h00, 5'h00, 5'h00, 5'h1C),
               20'h0};
        go(1'b1, v4(1, 2, 3, 4), 1'b0, 1'b0);
        go(1'b1, v4(5, 6, 7, 8), 1'b0, 1'b0);
        go(1'b1, v4(9, 10, 11, 12), 1'b1, 1'b0);
        rows("t2_rows", t2[0]);
        for (int i = 1; i < 7; i++) begin
            go(1'b0, '0, 1'b0, 1'b0);
            rows("t2_rows", t2[i]);
            chk1("t2_done", done, i == 5);
        end
        chk1("t2_idle", busy, 1'b0);

        // Fill under stall, fifth held off until space frees up
        go(1'b1, 16'h1111, 1'b0, 1'b1);
        chk1("t3_ready0", in_ready, 1'b1);
        chk1("t3_ce", mac_ce, 1'b0);
        go(1'b1, 16'h2222, 1'b0, 1'b1);
        chk1("t3_ready1", in_ready, 1'b1);
        go(1'b1, 16'h3333, 1'b0, 1'b1);
        chk1("t3_ready2", in_ready, 1'b1);
        go(1'b1, 16'h4444, 1'b0, 1'b1);
        chk1("t3_ready3", in_ready, 1'b1);
        go(1'b1, 16'h5555, 1'b1, 1'b1);
        chk1("t3_full", in_ready, 1'b0);
        go(1'b1, 16'h5555, 1'b1, 1'b1);
        chk1("t3_full_hold", in_ready, 1'b0);
        rows("t3_stalled", 20'h0);
        chk1("t3_busy_stalled", busy, 1'b0);
        go(1'b1, 16'h5555, 1'b1, 1'b0);
        chk1("t3_full_release", in_ready, 1'b0);
        chk1("t3_ce_on", mac_ce, 1'b1);
        t3 = '{mk(5'h11, 5'h00, 5'h00, 5'h00), mk(5'h12, 5'h11, 5'h00, 5'h00),
               mk(5'h13, 5'h12, 5'h11, 5'h00), mk(5'h14, 5'h13, 5'h12, 5'h11),
               mk(5'h15, 5'h14, 5'h13, 5'h12), mk(5'h00, 5'h15, 5'h14, 5'h13),
               mk(5'h00, 5'h00, 5'h15, 5'h14), mk(5'h00, 5'h00, 5'h00, 5'h15),
               20'h0};
        go(1'b1, 16'h5555, 1'b1, 1'b0);
        chk1("t3_space", in_ready, 1'b1);
        rows("t3_rows", t3[0]);
        for (int i = 1; i < 9; i++) begin
            go(1'b0, '0, 1'b0, 1'b0);
            rows("t3_rows", t3[i]);
            chk1("t3_done", done, i == 7);
        end
        chk1("t3_idle", busy, 1'b0);

        // Two-cycle stall mid-stream
        go(1'b1, 16'h7777, 1'b0, 1'b0);
        go(1'b1, 16'h8888, 1'b0, 1'b0);
        go(1'b1, 16'h9999, 1'b1, 1'b0);
        rows("t4_a", mk(5'h17, 5'h00, 5'h00, 5'h00));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_b", mk(5'h18, 5'h17, 5'h00, 5'h00));
        go(1'b0, '0, 1'b0, 1'b1);
        rows("t4_c", mk(5'h19, 5'h18, 5'h17, 5'h00));
        chk1("t4_ce0", mac_ce, 1'b0);
        go(1'b0, '0, 1'b0, 1'b1);
        rows("t4_hold1", mk(5'h19, 5'h18, 5'h17, 5'h00));
        chk1("t4_ce1", mac_ce, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_hold2", mk(5'h19, 5'h18, 5'h17, 5'h00));
        chk1("t4_ce2", mac_ce, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_d", mk(5'h00, 5'h19, 5'h18, 5'h17));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_e", mk(5'h00, 5'h00, 5'h19, 5'h18));
        chk1("t4_nodone", done, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_f", mk(5'h00, 5'h00, 5'h00, 5'h19));
        chk1("t4_done", done, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t4_end", 20'h0);
        chk1("t4_idle", busy, 1'b0);

        // Vector pushed during DRAIN waits until the cycle after done
        go(1'b1, 16'h3333, 1'b1, 1'b0);
        go(1'b1, 16'h5555, 1'b1, 1'b0);
        chk1("t5_ready", in_ready, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_a", mk(5'h13, 5'h00, 5'h00, 5'h00));
        chk1("t5_busy", busy, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_nopop", mk(5'h00, 5'h13, 5'h00, 5'h00));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_b", mk(5'h00, 5'h00, 5'h13, 5'h00));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_c", mk(5'h00, 5'h00, 5'h00, 5'h13));
        chk1("t5_done", done, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_gap", 20'h0);
        chk1("t5_idle", busy, 1'b0);
        chk1("t5_done_off", done, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_d_row0", mk(5'h15, 5'h00, 5'h00, 5'h00));
        chk1("t5_busy_d", busy, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t5_d_row3", mk(5'h00, 5'h00, 5'h00, 5'h15));
        chk1("t5_d_done", done, 1'b1);
        go(1'b0, '0, 1'b0, 1'b0);
        chk1("t5_end", busy, 1'b0);

        // Asynchronous reset while draining
        go(1'b1, 16'h9999, 1'b1, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t6_a", mk(5'h19, 5'h00, 5'h00, 5'h00));
        go(1'b0, '0, 1'b0, 1'b0);
        rows("t6_b", mk(5'h00, 5'h19, 5'h00, 5'h00));
        reset = 1'b1;
        #1;
        rows("t6_rst_rows", 20'h0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_done", done, 1'b0);
        go(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk1("t6_ready", in_ready, 1'b1);
        chk1("t6_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            go(1'b0, '0, 1'b0, 1'b0);
            rows("t6_quiet", 20'h0);
            chk1("t6_no_done", done, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
